// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle ALU ops, bit-serial SLL/SRL,
// valid/ready handshake on request and result sides.
module alu_seq_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    // state   | meaning
    // S_IDLE  | waiting for a request, in_ready high
    // S_SHIFT | shifting working register one bit per cycle
    // S_DONE  | result presented, waiting for out_ready

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   work;
    logic [SHW-1:0]    count;
    logic              shift_right;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   work_shifted;
    logic [XLEN-1:0]   result_nxt;
    logic              load_result;
    logic              accept;
    logic              is_shift;
    logic              slt_bit;
    logic [SHW-1:0]    shamt;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign shamt     = src_b[SHW-1:0];
    assign slt_bit   = ($signed(src_a) < $signed(src_b));

    assign work_shifted = shift_right ? (work >> 1) : (work << 1);

    always_comb begin
        alu_res = '0;
        case (alu_control)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            // zero-amount shifts pass src_a straight through
            default: alu_res = src_a;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        load_result = 1'b0;
        result_nxt  = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!is_shift || (shamt == '0)) begin
                        load_result = 1'b1;
                        result_nxt  = alu_res;
                        state_nxt   = S_DONE;
                    end else begin
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (count == SHW'(1)) begin
                    load_result = 1'b1;
                    result_nxt  = work_shifted;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work        <= '0;
            count       <= '0;
            shift_right <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
        end else begin
            if (accept && is_shift) begin
                work        <= src_a;
                count       <= shamt;
                shift_right <= (alu_control == OP_SRL);
            end else if (state == S_SHIFT) begin
                work  <= work_shifted;
                count <= count - SHW'(1);
            end
            if (load_result) begin
                result <= result_nxt;
                zero   <= (result_nxt == '0);
            end
        end
    end

endmodule
